pwm_rampa_motor: RTL and testbench
==================================

Name: pwm_rampa_motor

Overview:
- Downstream stage of the ramp-start speed FSM. Consumes its one-hot speed levels (30 %, 50 %, 100 %) and drives the motor PWM output.
- Duty cycle slews toward the selected level in fixed steps, once every N PWM periods, rather than jumping.
- Illegal multi-hot selection forces an immediate stop and raises a fault flag.

Parameters:
- W, 8, width of the PWM counter and duty registers.
- PERIOD, 100, PWM period in clk cycles; counter runs 0..PERIOD-1; must satisfy PERIOD <= 2^W-1.
- DUTY_30, 30, target duty in counts for in_30.
- DUTY_50, 50, target duty in counts for in_50.
- DUTY_100, 100, target duty in counts for in_100; must be <= PERIOD.
- STEP, 5, duty increment/decrement per ramp tick; must be >= 1.
- RAMP_PERIODS, 4, number of PWM periods between ramp ticks; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_30  input  1  speed level 30 % from the ramp FSM.
- in_50  input  1  speed level 50 % from the ramp FSM.
- in_100  input  1  speed level 100 % from the ramp FSM.
- pwm_out  output  1  registered motor PWM.
- duty_actual  output  W  current applied duty, in counts.
- rampa_activa  output  1  high while duty_actual != target.
- falla  output  1  high while the selection is multi-hot.
- estado  output  3  FSM state: 0 REPOSO, 1 SUBIENDO, 2 BAJANDO, 3 ESTABLE, 4 FALLA.

Behaviour:
- Reset (asynchronous): cnt=0, rdiv=0, tgt=0, duty_actual=0, pwm_out=0, rampa_activa=0, falla=0, estado=REPOSO.
- Input sampling: the in_* signals are registered every clk, giving 1 cycle of latency.
- Target derivation from the registered selection:
  - none asserted: tgt=0.
  - exactly one asserted: tgt = the matching DUTY_x.
  - two or more asserted: fault condition, tgt=0.
- PWM counter:
  - cnt increments every clk and wraps from PERIOD-1 to 0.
  - period_end = (cnt == PERIOD-1).
- Ramp divider:
  - rdiv counts period_end events, 0..RAMP_PERIODS-1, then wraps.
  - tick = period_end AND (rdiv == RAMP_PERIODS-1).
  - With RAMP_PERIODS=1, every period_end is a tick.
- Duty update on a tick:
  - duty < tgt: duty = min(duty+STEP, tgt).
  - duty > tgt: duty = max(duty-STEP, tgt), with no underflow.
  - duty == tgt: duty holds.
- Duty changes only on a tick, so every update falls on a period boundary and no PWM period is glitched.
- Arithmetic: compute sum and difference in W+1 bits before clamping.
- pwm_out: registered as (cnt < duty_actual).
  - duty 0: output constantly low.
  - duty == PERIOD: output constantly high.
  - duty 30 with PERIOD 100: high for exactly 30 consecutive cycles per period.
- FSM transitions, evaluated every clk in this priority order:
  - Fault condition from any state: go to FALLA. Next clk: duty_actual=0, falla=1, pwm_out=0 on the following edge. This bypasses the ramp and does not wait for a tick.
  - FALLA: once the selection is legal again, go to REPOSO with falla=0. Any new target then ramps up from 0.
  - tgt > duty: SUBIENDO.
  - tgt < duty: BAJANDO.
  - tgt == duty != 0: ESTABLE.
  - tgt == duty == 0: REPOSO.
- rampa_activa = (estado == SUBIENDO or estado == BAJANDO).
- Target change mid-ramp: the new tgt applies from the next tick. Direction may reverse without first reaching the old target.
- cnt and rdiv run freely in every state, including FALLA and REPOSO.
- Reset mid-operation: all registers clear immediately. After release, the ramp restarts from duty 0 and cnt 0.

Test Plan:
- Reset value check: assert reset mid-period → all outputs go to their reset values asynchronously (pwm_out=0, duty_actual=0, estado=0); after release cnt restarts at 0.
- Ramp up: in_30=1 from REPOSO (defaults) → duty_actual steps 0→5→10→…→30, one step every 400 cycles; estado=SUBIENDO during the ramp, ESTABLE after; then pwm_out high for exactly 30 of every 100 cycles.
- Level change: from ESTABLE at 30, switch to in_100 → ramps 30→100 in 14 ticks; then pwm_out stays constantly high; drop all inputs → BAJANDO, ramps to 0, ends in REPOSO.
- Step clamp: STEP=15, in_50 → duty sequence 0,15,30,45,50, no overshoot; reverse to in_30 at duty 45 → 30 on the next tick.
- Fault: at duty 50 assert in_30 and in_100 together → falla=1 and estado=FALLA 2 clk after the inputs change; duty_actual=0 the same cycle; pwm_out=0 one cycle later; release to in_50 alone → REPOSO, then SUBIENDO from 0.
- Divider edge: RAMP_PERIODS=1, PERIOD=10, in_100 with DUTY_100=10, STEP=5 → duty reaches 10 after 2 periods; pwm_out constantly high.

Source files
------------

// File: rtl/pwm_rampa_motor.sv
// Motor PWM stage: slews the applied duty toward the one-hot speed level selected
// by the ramp-start FSM, one step every RAMP_PERIODS PWM periods; multi-hot forces a stop.
module pwm_rampa_motor #(
    parameter int W            = 8,
    parameter int PERIOD       = 100,
    parameter int DUTY_30      = 30,
    parameter int DUTY_50      = 50,
    parameter int DUTY_100     = 100,
    parameter int STEP         = 5,
    parameter int RAMP_PERIODS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_30,
    input  logic         in_50,
    input  logic         in_100,
    output logic         pwm_out,
    output logic [W-1:0] duty_actual,
    output logic         rampa_activa,
    output logic         falla,
    output logic [2:0]   estado
);

    localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam int WX = W + 1;

    typedef enum logic [2:0] {
        REPOSO   = 3'd0,
        SUBIENDO = 3'd1,
        BAJANDO  = 3'd2,
        ESTABLE  = 3'd3,
        FALLA    = 3'd4
    } state_t;

    logic [2:0]    r_sel;
    logic [W-1:0]  r_cnt;
    logic [RW-1:0] r_rdiv;
    logic [W-1:0]  r_duty;
    logic          r_pwm;
    logic          r_falla;
    state_t        r_estado;

    logic          w_fault;
    logic          w_period_end;
    logic          w_tick;
    logic [W-1:0]  w_tgt;
    logic [W-1:0]  w_up;
    logic [W-1:0]  w_down;
    logic [WX-1:0] w_sum;
    logic [WX-1:0] w_diff;

    assign w_fault = (r_sel[0] & r_sel[1]) | (r_sel[0] & r_sel[2]) | (r_sel[1] & r_sel[2]);

    always_comb begin
        // NOTE: default assigned first so every path drives w_tgt and no latch is inferred.
        w_tgt = '0;
        case (r_sel)
            3'b001:  w_tgt = W'(DUTY_30);
            3'b010:  w_tgt = W'(DUTY_50);
            3'b100:  w_tgt = W'(DUTY_100);
            default: w_tgt = '0;
        endcase
    end

    assign w_period_end = (r_cnt == W'(PERIOD - 1));
    assign w_tick       = w_period_end && (r_rdiv == RW'(RAMP_PERIODS - 1));

    // One extra bit catches overflow on the way up and borrow on the way down.
    assign w_sum  = {1'b0, r_duty} + WX'(STEP);
    assign w_diff = {1'b0, r_duty} - WX'(STEP);
    assign w_up   = (w_sum > {1'b0, w_tgt}) ? w_tgt : w_sum[W-1:0];
    assign w_down = (w_diff[W] || (w_diff[W-1:0] < w_tgt)) ? w_tgt : w_diff[W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel  <= '0;
            r_cnt  <= '0;
            r_rdiv <= '0;
            r_pwm  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_sel <= {in_100, in_50, in_30};
            r_cnt <= w_period_end ? '0 : r_cnt + 1'b1;
            if (w_period_end) begin
                r_rdiv <= (r_rdiv == RW'(RAMP_PERIODS - 1)) ? '0 : r_rdiv + 1'b1;
            end
            r_pwm <= (r_cnt < r_duty);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_duty   <= '0;
            r_falla  <= 1'b0;
            r_estado <= REPOSO;
        end else if (w_fault) begin
            r_duty   <= '0;
            r_falla  <= 1'b1;
            r_estado <= FALLA;
        end else if (r_estado == FALLA) begin
            r_falla  <= 1'b0;
            r_estado <= REPOSO;
        end else begin
            r_falla <= 1'b0;
            // Duty only moves on a tick, which always coincides with a period boundary.
            if (w_tick) begin
                if (r_duty < w_tgt) begin
                    r_duty <= w_up;
                end else if (r_duty > w_tgt) begin
                    r_duty <= w_down;
                end
            end
            if (w_tgt > r_duty) begin
                r_estado <= SUBIENDO;
            end else if (w_tgt < r_duty) begin
                r_estado <= BAJANDO;
            end else if (r_duty != '0) begin
                r_estado <= ESTABLE;
            end else begin
                r_estado <= REPOSO;
            end
        end
    end

    assign pwm_out      = r_pwm;
    assign duty_actual  = r_duty;
    assign falla        = r_falla;
    assign estado       = r_estado;
    assign rampa_activa = (r_estado == SUBIENDO) || (r_estado == BAJANDO);

endmodule

// File: tb/tb_pwm_rampa_motor.sv
// Directed bench for pwm_rampa_motor: three instances cover the default build,
// a coarse STEP=15 build and a short-period RAMP_PERIODS=1 build.
module tb_pwm_rampa_motor;

    localparam logic [2:0] S_REP = 3'd0;
    localparam logic [2:0] S_SUB = 3'd1;
    localparam logic [2:0] S_BAJ = 3'd2;
    localparam logic [2:0] S_EST = 3'd3;
    localparam logic [2:0] S_FAL = 3'd4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] v30, v50, v100;

    logic       pwm_w   [3];
    logic [7:0] duty_w  [3];
    logic       ramp_w  [3];
    logic       falla_w [3];
    logic [2:0] est_w   [3];

    logic [7:0] exp_duty [3];
    int         checks   = 0;
    int         failures = 0;
    int         cyc;

    always #5 clk = ~clk;

    // Rising edges seen since reset was last released.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    pwm_rampa_motor dut (
        .clk(clk), .reset(reset), .in_30(v30[0]), .in_50(v50[0]), .in_100(v100[0]),
        .pwm_out(pwm_w[0]), .duty_actual(duty_w[0]), .rampa_activa(ramp_w[0]),
        .falla(falla_w[0]), .estado(est_w[0])
    );

    pwm_rampa_motor #(.STEP(15)) dut_s (
        .clk(clk), .reset(reset), .in_30(v30[1]), .in_50(v50[1]), .in_100(v100[1]),
        .pwm_out(pwm_w[1]), .duty_actual(duty_w[1]), .rampa_activa(ramp_w[1]),
        .falla(falla_w[1]), .estado(est_w[1])
    );

    pwm_rampa_motor #(.PERIOD(10), .DUTY_30(3), .DUTY_50(5), .DUTY_100(10),
                      .STEP(5), .RAMP_PERIODS(1)) dut_d (
        .clk(clk), .reset(reset), .in_30(v30[2]), .in_50(v50[2]), .in_100(v100[2]),
        .pwm_out(pwm_w[2]), .duty_actual(duty_w[2]), .rampa_activa(ramp_w[2]),
        .falla(falla_w[2]), .estado(est_w[2])
    );

    function automatic int pwm_per(input int i);
        return (i == 2) ? 10 : 100;
    endfunction

    function automatic int tick_per(input int i);
        return (i == 2) ? 10 : 400;
    endfunction

    // Waits for nsteps duty changes on instance i, checking value, spacing and state.
    task automatic ramp(input int i, input int tgt, input int step, input int nsteps,
                        input logic [2:0] st, input string tag);
        int tp, gap, n, e, nx;
        tp  = tick_per(i);
        gap = ((cyc + 2 + tp - 1) / tp) * tp - cyc;
        for (int k = 0; k < nsteps; k++) begin
            e = int'(exp_duty[i]);
            if (e < tgt)      nx = (e + step > tgt) ? tgt : e + step;
            else if (e > tgt) nx = (e - step < tgt) ? tgt : e - step;
            else              nx = e;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (duty_w[i] == exp_duty[i] && n < gap + 10);
            checks++;
            if (duty_w[i] !== 8'(nx)) begin
                failures++;
                $display("FAIL %s step%0d duty: got %0d expected %0d", tag, k, duty_w[i], nx);
            end
            checks++;
            if (n != gap) begin
                failures++;
                $display("FAIL %s step%0d spacing: got %0d cycles expected %0d", tag, k, n, gap);
            end
            checks++;
            if (est_w[i] !== st || ramp_w[i] !== 1'b1) begin
                failures++;
                $display("FAIL %s step%0d state: got estado=%0d rampa=%0b expected estado=%0d rampa=1",
                         tag, k, est_w[i], ramp_w[i], st);
            end
            exp_duty[i] = 8'(nx);
            gap = tp;
        end
    endtask

    // Samples pwm_out for n cycles; the output at edge c reflects counter value (c-1).
    task automatic pwm_window(input int i, input int n, input string tag);
        int  mism, first;
        logic e;
        mism  = 0;
        first = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            e = (((cyc - 1) % pwm_per(i)) < int'(exp_duty[i]));
            if (pwm_w[i] !== e) begin
                mism++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (mism != 0) begin
            failures++;
            $display("FAIL %s pwm pattern: got %0d wrong samples (first at %0d) expected 0", tag, mism, first);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        v30 = '0; v50 = '0; v100 = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({pwm_w[i], duty_w[i], ramp_w[i], falla_w[i], est_w[i]} !== 13'd0) begin
                failures++;
                $display("FAIL reset inst%0d: got pwm=%0b duty=%0d rampa=%0b falla=%0b estado=%0d expected all 0",
                         i, pwm_w[i], duty_w[i], ramp_w[i], falla_w[i], est_w[i]);
            end
            exp_duty[i] = 8'd0;
        end
        reset = 1'b0;
    endtask

    task automatic test_ramp_up;
        v30[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (est_w[0] !== S_REP) begin
            failures++;
            $display("FAIL ramp_up latency1: got estado=%0d expected %0d", est_w[0], S_REP);
        end
        @(negedge clk);
        checks++;
        if (est_w[0] !== S_SUB) begin
            failures++;
            $display("FAIL ramp_up latency2: got estado=%0d expected %0d", est_w[0], S_SUB);
        end
        ramp(0, 30, 5, 6, S_SUB, "ramp_up");
        @(negedge clk);
        checks++;
        if (est_w[0] !== S_EST || ramp_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL ramp_up settle: got estado=%0d rampa=%0b expected %0d rampa=0",
                     est_w[0], ramp_w[0], S_EST);
        end
        pwm_window(0, 100, "duty30");
    endtask

    task automatic test_level_change;
        v30[0]  = 1'b0;
        v100[0] = 1'b1;
        ramp(0, 100, 5, 14, S_SUB, "to100");
        @(negedge clk);
        checks++;
        if (est_w[0] !== S_EST) begin
            failures++;
            $display("FAIL to100 settle: got estado=%0d expected %0d", est_w[0], S_EST);
        end
        pwm_window(0, 100, "duty100");
        v100[0] = 1'b0;
        ramp(0, 0, 5, 20, S_BAJ, "to0");
        @(negedge clk);
        checks++;
        if (est_w[0] !== S_REP || ramp_w[0] !== 1'b0 || pwm_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL to0 settle: got estado=%0d rampa=%0b pwm=%0b expected %0d rampa=0 pwm=0",
                     est_w[0], ramp_w[0], pwm_w[0], S_REP);
        end
    endtask

    task automatic test_step_clamp;
        v50[1] = 1'b1;
        ramp(1, 50, 15, 3, S_SUB, "clamp_up");
        v50[1] = 1'b0;
        v30[1] = 1'b1;
        ramp(1, 30, 15, 1, S_BAJ, "reverse");
        @(negedge clk);
        checks++;
        if (est_w[1] !== S_EST) begin
            failures++;
            $display("FAIL reverse settle: got estado=%0d expected %0d", est_w[1], S_EST);
        end
        v30[1] = 1'b0;
        v50[1] = 1'b1;
        ramp(1, 50, 15, 2, S_SUB, "clamp50");
        @(negedge clk);
        checks++;
        if (est_w[1] !== S_EST || duty_w[1] !== 8'd50) begin
            failures++;
            $display("FAIL clamp50 settle: got estado=%0d duty=%0d expected %0d duty=50",
                     est_w[1], duty_w[1], S_EST);
        end
    endtask

    task automatic test_fault;
        v50[1]  = 1'b0;
        v30[1]  = 1'b1;
        v100[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (falla_w[1] !== 1'b0 || est_w[1] !== S_EST || duty_w[1] !== 8'd50) begin
            failures++;
            $display("FAIL fault early: got falla=%0b estado=%0d duty=%0d expected 0 %0d 50",
                     falla_w[1], est_w[1], duty_w[1], S_EST);
        end
        @(negedge clk);
        checks++;
        if (falla_w[1] !== 1'b1 || est_w[1] !== S_FAL || duty_w[1] !== 8'd0 || ramp_w[1] !== 1'b0) begin
            failures++;
            $display("FAIL fault entry: got falla=%0b estado=%0d duty=%0d rampa=%0b expected 1 %0d 0 0",
                     falla_w[1], est_w[1], duty_w[1], ramp_w[1], S_FAL);
        end
        exp_duty[1] = 8'd0;
        pwm_window(1, 450, "fault_hold");
        checks++;
        if (est_w[1] !== S_FAL || duty_w[1] !== 8'd0 || falla_w[1] !== 1'b1) begin
            failures++;
            $display("FAIL fault hold: got estado=%0d duty=%0d falla=%0b expected %0d 0 1",
                     est_w[1], duty_w[1], falla_w[1], S_FAL);
        end
        v30[1]  = 1'b0;
        v100[1] = 1'b0;
        v50[1]  = 1'b1;
        @(negedge clk);
        checks++;
        if (est_w[1] !== S_FAL || falla_w[1] !== 1'b1) begin
            failures++;
            $display("FAIL release1: got estado=%0d falla=%0b expected %0d 1", est_w[1], falla_w[1], S_FAL);
        end
        @(negedge clk);
        checks++;
        if (est_w[1] !== S_REP || falla_w[1] !== 1'b0) begin
            failures++;
            $display("FAIL release2: got estado=%0d falla=%0b expected %0d 0", est_w[1], falla_w[1], S_REP);
        end
        @(negedge clk);
        checks++;
        if (est_w[1] !== S_SUB || duty_w[1] !== 8'd0) begin
            failures++;
            $display("FAIL release3: got estado=%0d duty=%0d expected %0d 0", est_w[1], duty_w[1], S_SUB);
        end
        ramp(1, 50, 15, 1, S_SUB, "restart");
    endtask

    task automatic test_divider;
        v100[2] = 1'b1;
        ramp(2, 10, 5, 2, S_SUB, "div");
        @(negedge clk);
        checks++;
        if (est_w[2] !== S_EST) begin
            failures++;
            $display("FAIL div settle: got estado=%0d expected %0d", est_w[2], S_EST);
        end
        pwm_window(2, 30, "div_full");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        checks++;
        if (pwm_w[2] !== 1'b1 || duty_w[1] !== 8'd15) begin
            failures++;
            $display("FAIL pre_reset: got pwm_d=%0b duty_s=%0d expected 1 15", pwm_w[2], duty_w[1]);
        end
        #3 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({pwm_w[i], duty_w[i], ramp_w[i], falla_w[i], est_w[i]} !== 13'd0) begin
                failures++;
                $display("FAIL async_reset inst%0d: got pwm=%0b duty=%0d rampa=%0b falla=%0b estado=%0d expected all 0",
                         i, pwm_w[i], duty_w[i], ramp_w[i], falla_w[i], est_w[i]);
            end
            exp_duty[i] = 8'd0;
        end
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        v100[0] = 1'b1;
        ramp(2, 10, 5, 1, S_SUB, "post_reset_d");
        ramp(0, 100, 5, 1, S_SUB, "post_reset");
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_level_change();
        test_step_clamp();
        test_fault();
        test_divider();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
